// File: rtl/bfloat_mac_stream.sv
// bfloat_mac_stream: pipelined floating-point dot-product engine (S1 operands, S2 product, S3 accumulator).
// Optional macro BFLOAT_MAC_SAT_EN: exponent overflow saturates to signed max finite instead of infinity.
module bfloat_mac_stream #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 7,
  parameter int ACC_LEN = 16,
  localparam int W      = 1 + EXP_W + MAN_W,
  localparam int CNT_W  = $clog2(ACC_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] out_count,
  output logic [1:0]       dbg_state
);

  localparam int EW = EXP_W + 2;
  localparam logic [EXP_W-1:0]    EXP_ONES = '1;
  localparam logic [EXP_W-1:0]    EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = EW'(0);
  localparam logic signed [EW-1:0] E_BIAS = EW'(2**(EXP_W-1) - 1);
  localparam logic signed [EW-1:0] E_MAX  = EW'(2**EXP_W - 1);
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {ACCUM = 2'd0, DRAIN = 2'd1, HOLD = 2'd2} state_t;

  function automatic logic is_nan(input logic [W-1:0] x);
    return (x[W-2:MAN_W] == EXP_ONES) && (x[MAN_W-1:0] != '0);
  endfunction

  function automatic logic is_inf(input logic [W-1:0] x);
    return (x[W-2:MAN_W] == EXP_ONES) && (x[MAN_W-1:0] == '0);
  endfunction

  // Exponent zero covers both true zero and subnormals, which are flushed.
  function automatic logic is_zero(input logic [W-1:0] x);
    return x[W-2:MAN_W] == '0;
  endfunction

  function automatic logic [W-1:0] ovf(input logic s);
`ifdef BFLOAT_MAC_SAT_EN
    return {s, EXP_MAXF, {MAN_W{1'b1}}};
`else
    return {s, EXP_ONES, {MAN_W{1'b0}}};
`endif
  endfunction

  function automatic logic [W-1:0] pack(input logic s, input logic signed [EW-1:0] e,
                                        input logic [MAN_W-1:0] m);
    if (e >= E_MAX)       return ovf(s);
    else if (e <= E_ZERO) return {s, {(W-1){1'b0}}};
    else                  return {s, e[EXP_W-1:0], m};
  endfunction

  function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic s;
    logic [2*MAN_W+1:0] p;
    logic signed [EW-1:0] e;
    logic [MAN_W-1:0] m;
    s = a[W-1] ^ b[W-1];
    p = {1'b1, a[MAN_W-1:0]} * {1'b1, b[MAN_W-1:0]};
    e = $signed({2'b00, a[W-2:MAN_W]}) + $signed({2'b00, b[W-2:MAN_W]}) - E_BIAS;
    if (p[2*MAN_W+1]) begin
      m = p[2*MAN_W -: MAN_W];
      e = e + E_ONE;
    end else begin
      m = p[2*MAN_W-1 -: MAN_W];
    end
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_zero(b)) || (is_inf(b) && is_zero(a)))
      return QNAN;
    else if (is_inf(a) || is_inf(b)) return {s, EXP_ONES, {MAN_W{1'b0}}};
    else if (is_zero(a) || is_zero(b)) return {s, {(W-1){1'b0}}};
    else return pack(s, e, m);
  endfunction

  function automatic logic [W-1:0] fadd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] big, sml;
    logic [EXP_W-1:0] d;
    logic [MAN_W:0] mbig, msml, diff, norm;
    logic [MAN_W+1:0] sum;
    logic signed [EW-1:0] e;
    logic [MAN_W-1:0] m;
    int lz;
    if (is_nan(x) || is_nan(y)) return QNAN;
    if (is_inf(x) && is_inf(y) && (x[W-1] != y[W-1])) return QNAN;
    if (is_inf(x)) return x;
    if (is_inf(y)) return y;
    if (is_zero(x) && is_zero(y)) return '0;
    if (is_zero(x)) return y;
    if (is_zero(y)) return x;
    if (x[W-2:0] < y[W-2:0]) begin big = y; sml = x; end
    else                     begin big = x; sml = y; end
    d    = big[W-2:MAN_W] - sml[W-2:MAN_W];
    mbig = {1'b1, big[MAN_W-1:0]};
    msml = {1'b1, sml[MAN_W-1:0]} >> d;
    e    = $signed({2'b00, big[W-2:MAN_W]});
    if (big[W-1] == sml[W-1]) begin
      sum = {1'b0, mbig} + {1'b0, msml};
      if (sum[MAN_W+1]) begin
        m = sum[MAN_W:1];
        e = e + E_ONE;
      end else begin
        m = sum[MAN_W-1:0];
      end
      return pack(big[W-1], e, m);
    end
    diff = mbig - msml;
    if (diff == '0) return '0;
    // Highest set bit wins because the scan runs upward.
    lz = 0;
    for (int i = 0; i <= MAN_W; i++) if (diff[i]) lz = MAN_W - i;
    norm = diff << lz;
    m    = norm[MAN_W-1:0];
    e    = e - EW'(lz);
    return pack(big[W-1], e, m);
  endfunction

  state_t state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0] acc, s1_a, s1_b, s2_p;
  logic s1_valid, s1_last, s2_valid, s2_last;
  logic hs, close;

  // A pair moves when in_valid && in_ready on a rising edge; a result moves when
  // out_valid && out_ready; neither valid waits on ready, and ready never depends on valid.
  assign in_ready  = (state == ACCUM) && !rst;
  assign hs        = in_valid && in_ready;
  assign close     = in_last || (cnt == CNT_W'(ACC_LEN - 1));
  assign out_valid = (state == HOLD);
  assign out_data  = acc;
  assign out_count = cnt;
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (hs && close) state_next = DRAIN;
      DRAIN:   if (s2_valid && s2_last) state_next = HOLD;
      HOLD:    if (out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      cnt      <= '0;
      acc      <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_p     <= '0;
    end else begin
      state    <= state_next;
      s1_valid <= hs;
      if (hs) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_last <= close;
      end
      s2_valid <= s1_valid;
      s2_last  <= s1_valid && s1_last;
      s2_p     <= fmul(s1_a, s1_b);
      if (state == HOLD && out_ready) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        if (s2_valid) acc <= fadd(acc, s2_p);
        if (hs) cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
